// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS encoder: video (8b/10b DC-balanced), control, TERC4 data island and guard bands.
// Optional per-lane disparity monitor outputs are enabled with `define TMDS_DISP_MON_EN.
module tmds_encoder_mc #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned IN_REG = 1,
    parameter int unsigned ACC_W  = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ce,
    input  logic [2:0]              i_mode,
    input  logic [NUM_CH*8-1:0]     i_data,
    input  logic [NUM_CH*2-1:0]     i_ctrl,
    input  logic [NUM_CH*4-1:0]     i_aux,
    output logic [NUM_CH*10-1:0]    o_encoded
`ifdef TMDS_DISP_MON_EN
    ,
    output logic [NUM_CH*ACC_W-1:0] o_disparity,
    output logic                    o_dc_err
`endif
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_DATA   = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    localparam logic [9:0] CODE_CTRL00 = 10'b1101010100;
    localparam logic [9:0] GUARD_A     = 10'b1011001100;
    localparam logic [9:0] GUARD_B     = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + 4'(d[i]);
        return c;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = 10'b1101010100;
            2'b01:   w = 10'b0010101011;
            2'b10:   w = 10'b0101010100;
            default: w = 10'b1010101011;
        endcase
        return w;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] n);
        logic [9:0] w;
        case (n)
            4'h0:    w = 10'b1010011100;
            4'h1:    w = 10'b1001100011;
            4'h2:    w = 10'b1011100100;
            4'h3:    w = 10'b1011100010;
            4'h4:    w = 10'b0101110001;
            4'h5:    w = 10'b0100011110;
            4'h6:    w = 10'b0110001110;
            4'h7:    w = 10'b0100111100;
            4'h8:    w = 10'b1011001100;
            4'h9:    w = 10'b0100111001;
            4'hA:    w = 10'b0110011100;
            4'hB:    w = 10'b1011000110;
            4'hC:    w = 10'b1010001110;
            4'hD:    w = 10'b1001110001;
            4'hE:    w = 10'b0101100011;
            default: w = 10'b1011000011;
        endcase
        return w;
    endfunction

    // Transition minimisation: q_m[8]=1 selects the XOR chain, 0 the XNOR chain.
    function automatic logic [8:0] tm_min(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ use_xnor;
        q[8]     = ~use_xnor;
        return q;
    endfunction

    logic [NUM_CH*9-1:0] qm_c;

    always_comb begin
        qm_c = '0;
        for (int ch = 0; ch < NUM_CH; ch++) qm_c[ch*9 +: 9] = tm_min(i_data[ch*8 +: 8]);
    end

    logic [2:0]          s1_mode;
    logic [NUM_CH*9-1:0] s1_qm;
    logic [NUM_CH*2-1:0] s1_ctrl;
    logic [NUM_CH*4-1:0] s1_aux;

    generate
        if (IN_REG != 0) begin : g_in_reg
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    s1_mode <= MODE_CTRL;
                    s1_qm   <= '0;
                    s1_ctrl <= '0;
                    s1_aux  <= '0;
                end else if (i_ce) begin
                    s1_mode <= i_mode;
                    s1_qm   <= qm_c;
                    s1_ctrl <= i_ctrl;
                    s1_aux  <= i_aux;
                end
            end
        end else begin : g_no_reg
            assign s1_mode = i_mode;
            assign s1_qm   = qm_c;
            assign s1_ctrl = i_ctrl;
            assign s1_aux  = i_aux;
        end
    endgenerate

    logic signed [ACC_W-1:0] cnt_q  [NUM_CH];
    logic signed [ACC_W-1:0] cnt_nx [NUM_CH];
    logic [9:0]              enc_c  [NUM_CH];

    // Output stage: mode select and DC-balance update of the running disparity.
    always_comb begin : p_encode
        logic [8:0]              qm;
        logic [3:0]              n1;
        logic signed [ACC_W-1:0] cnt;
        logic signed [ACC_W-1:0] disp;
        logic signed [ACC_W-1:0] two_q8;
        logic signed [ACC_W-1:0] two_nq8;
        qm      = '0;
        n1      = '0;
        cnt     = '0;
        disp    = '0;
        two_q8  = '0;
        two_nq8 = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            qm          = s1_qm[ch*9 +: 9];
            n1          = ones8(qm[7:0]);
            cnt         = cnt_q[ch];
            disp        = ACC_W'({n1, 1'b0}) - ACC_W'(8);
            two_q8      = qm[8] ? ACC_W'(2) : '0;
            two_nq8     = qm[8] ? '0 : ACC_W'(2);
            enc_c[ch]   = ctrl_code(s1_ctrl[ch*2 +: 2]);
            cnt_nx[ch]  = '0;
            case (s1_mode)
                MODE_VIDEO: begin
                    if ((cnt == '0) || (disp == '0)) begin
                        enc_c[ch]  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                        cnt_nx[ch] = qm[8] ? (cnt + disp) : (cnt - disp);
                    end else if (cnt[ACC_W-1] == disp[ACC_W-1]) begin
                        enc_c[ch]  = {1'b1, qm[8], ~qm[7:0]};
                        cnt_nx[ch] = cnt + two_q8 - disp;
                    end else begin
                        enc_c[ch]  = {1'b0, qm[8], qm[7:0]};
                        cnt_nx[ch] = cnt + disp - two_nq8;
                    end
                end
                MODE_VGUARD: enc_c[ch] = (ch == 1) ? GUARD_B : GUARD_A;
                MODE_DATA:   enc_c[ch] = terc4(s1_aux[ch*4 +: 4]);
                MODE_DGUARD: enc_c[ch] = (ch == 0) ? terc4({2'b11, s1_ctrl[1:0]}) : GUARD_B;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_encoded <= {NUM_CH{CODE_CTRL00}};
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
        end else if (i_ce) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                o_encoded[ch*10 +: 10] <= enc_c[ch];
                cnt_q[ch]              <= cnt_nx[ch];
            end
        end
    end

`ifdef TMDS_DISP_MON_EN
    logic dc_err_c;

    always_comb begin
        dc_err_c = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if ((int'(cnt_nx[ch]) > 10) || (int'(cnt_nx[ch]) < -10)) dc_err_c = 1'b1;
        end
    end

    // Sticky imbalance flag; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_disparity <= '0;
            o_dc_err    <= 1'b0;
        end else if (i_ce) begin
            for (int ch = 0; ch < NUM_CH; ch++) o_disparity[ch*ACC_W +: ACC_W] <= cnt_nx[ch];
            o_dc_err <= o_dc_err | dc_err_c;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Bench for tmds_encoder_mc (NUM_CH=3, IN_REG=1): directed vector table plus random stream vs a reference model.
module tb_tmds_encoder_mc;

    localparam logic [9:0]  RST_LANE = 10'b1101010100;
    localparam logic [29:0] RST_WORD = {RST_LANE, RST_LANE, RST_LANE};

    logic        i_clk;
    logic        i_rst;
    logic        i_ce;
    logic [2:0]  i_mode;
    logic [23:0] i_data;
    logic [5:0]  i_ctrl;
    logic [11:0] i_aux;
    logic [29:0] o_encoded;
`ifdef TMDS_DISP_MON_EN
    logic [17:0] o_disparity;
    logic        o_dc_err;
`endif

    tmds_encoder_mc #(.NUM_CH(3), .IN_REG(1), .ACC_W(6)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ce      (i_ce),
        .i_mode    (i_mode),
        .i_data    (i_data),
        .i_ctrl    (i_ctrl),
        .i_aux     (i_aux),
        .o_encoded (o_encoded)
`ifdef TMDS_DISP_MON_EN
        ,
        .o_disparity (o_disparity),
        .o_dc_err    (o_dc_err)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference model state: running disparity per lane, and the two-word pipeline.
    int          mcnt [3];
    logic [29:0] exp_now;
    logic [29:0] pending;

    task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic video_lane(input int ch, input logic [7:0] d, output logic [9:0] o);
        int         n1;
        int         disp;
        logic       xn;
        logic       q8;
        logic [7:0] q;
        n1   = $countones(d);
        xn   = (n1 > 4) || (n1 == 4 && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ xn;
        q8   = ~xn;
        disp = 2 * $countones(q) - 8;
        if (mcnt[ch] == 0 || disp == 0) begin
            o = {~q8, q8, q8 ? q : ~q};
            mcnt[ch] += q8 ? disp : -disp;
        end else if ((mcnt[ch] > 0) == (disp > 0)) begin
            o = {1'b1, q8, ~q};
            mcnt[ch] += (q8 ? 2 : 0) - disp;
        end else begin
            o = {1'b0, q8, q};
            mcnt[ch] += disp - (q8 ? 0 : 2);
        end
    endtask

    task automatic model_word(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                              input logic [11:0] a, output logic [29:0] w);
        logic [9:0] lw;
        w = '0;
        for (int ch = 0; ch < 3; ch++) begin
            case (m)
                3'd1:    video_lane(ch, d[ch*8 +: 8], lw);
                3'd2:    lw = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
                3'd3:    lw = terc4_tab[a[ch*4 +: 4]];
                3'd4:    lw = (ch == 0) ? terc4_tab[{2'b11, c[1:0]}] : 10'b0100110011;
                default: lw = ctrl_tab[c[ch*2 +: 2]];
            endcase
            if (m != 3'd1) mcnt[ch] = 0;
            w[ch*10 +: 10] = lw;
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, then compare against the model.
    task automatic step(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                        input logic [11:0] a, input logic ce, input logic rst);
        i_mode = m;
        i_data = d;
        i_ctrl = c;
        i_aux  = a;
        i_ce   = ce;
        i_rst  = rst;
        @(posedge i_clk);
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
            exp_now = RST_WORD;
            pending = RST_WORD;
        end else if (ce) begin
            exp_now = pending;
            model_word(m, d, c, a, pending);
        end
        #1;
        check("model", o_encoded, exp_now);
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] aux;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{3'd1, 24'h000000, 6'b000000, 12'h000, {10'h100, 10'h100, 10'h100}};
        tbl[1]  = '{3'd1, 24'h000000, 6'b000000, 12'h000, {10'h3FF, 10'h3FF, 10'h3FF}};
        tbl[2]  = '{3'd0, 24'h000000, 6'b111001, 12'h000, {10'b1010101011, 10'b0101010100, 10'b0010101011}};
        tbl[3]  = '{3'd3, 24'h000000, 6'b000000, 12'hF05, {10'b1011000011, 10'b1010011100, 10'b0100011110}};
        tbl[4]  = '{3'd4, 24'h000000, 6'b000010, 12'h000, {10'b0100110011, 10'b0100110011, 10'b0101100011}};
        tbl[5]  = '{3'd1, 24'h000000, 6'b000000, 12'h000, {10'h100, 10'h100, 10'h100}};
        tbl[6]  = '{3'd0, 24'h000000, 6'b000000, 12'h000, RST_WORD};
        tbl[7]  = '{3'd1, 24'h000000, 6'b000000, 12'h000, {10'h100, 10'h100, 10'h100}};
        tbl[8]  = '{3'd2, 24'h000000, 6'b000000, 12'h000, {10'b1011001100, 10'b0100110011, 10'b1011001100}};
        tbl[9]  = '{3'd5, 24'h000000, 6'b000011, 12'h000, {RST_LANE, RST_LANE, 10'b1010101011}};
        tbl[10] = '{3'd1, 24'h000000, 6'b000000, 12'h000, {10'h100, 10'h100, 10'h100}};
        tbl[11] = '{3'd1, 24'hFFFFFF, 6'b000000, 12'h000, {10'h0FF, 10'h0FF, 10'h0FF}};

        for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
        exp_now = RST_WORD;
        pending = RST_WORD;

        // Reset state
        step(3'd1, 24'h123456, 6'b0, 12'h0, 1'b1, 1'b1);
        step(3'd1, 24'h123456, 6'b0, 12'h0, 1'b1, 1'b1);
        check("reset_code", o_encoded, RST_WORD);
`ifdef TMDS_DISP_MON_EN
        check("reset_disp", 30'(o_disparity), 30'd0);
        check("reset_dcerr", 30'(o_dc_err), 30'd0);
`endif

        // Directed vector table; word i appears after vector i+1 is clocked in
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].mode, tbl[i].data, tbl[i].ctrl, tbl[i].aux, 1'b1, 1'b0);
            if (i > 0) check($sformatf("vec%0d", i - 1), o_encoded, tbl[i-1].exp);
        end
        step(3'd0, 24'h0, 6'b0, 12'h0, 1'b1, 1'b0);
        check("vec11", o_encoded, tbl[11].exp);

        // Clock-enable gaps inside a video stream
        step(3'd0, 24'h0, 6'b0, 12'h0, 1'b1, 1'b0);
        step(3'd1, 24'h3C81A5, 6'b0, 12'h0, 1'b1, 1'b0);
        step(3'd1, 24'h3C81A5, 6'b0, 12'h0, 1'b0, 1'b0);
        step(3'd1, 24'h3C81A5, 6'b0, 12'h0, 1'b0, 1'b0);
        step(3'd1, 24'h0F7710, 6'b0, 12'h0, 1'b1, 1'b0);
        step(3'd1, 24'hE40099, 6'b0, 12'h0, 1'b0, 1'b0);
        step(3'd1, 24'hE40099, 6'b0, 12'h0, 1'b1, 1'b0);
        step(3'd0, 24'h0, 6'b0, 12'h0, 1'b1, 1'b0);

        // Reset mid video stream, then counter restarts from zero
        step(3'd1, 24'h000000, 6'b0, 12'h0, 1'b1, 1'b0);
        step(3'd1, 24'h000000, 6'b0, 12'h0, 1'b1, 1'b0);
        step(3'd1, 24'h000000, 6'b0, 12'h0, 1'b1, 1'b1);
        check("midrst_code", o_encoded, RST_WORD);
`ifdef TMDS_DISP_MON_EN
        check("midrst_disp", 30'(o_disparity), 30'd0);
        check("midrst_dcerr", 30'(o_dc_err), 30'd0);
`endif
        step(3'd1, 24'h000000, 6'b0, 12'h0, 1'b1, 1'b0);
        check("postrst_s1", o_encoded, RST_WORD);
        step(3'd1, 24'h000000, 6'b0, 12'h0, 1'b1, 1'b0);
        check("postrst_vid", o_encoded, {10'h100, 10'h100, 10'h100});

        // Random stream, mostly video, with ce gaps and rare resets
        for (int n = 0; n < 600; n++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 9) < 5) ? 3'd1 : 3'($urandom_range(0, 7));
            step(m, 24'($urandom()), 6'($urandom()), 12'($urandom()),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_mc.md
Name: tmds_encoder_mc

Overview:
Parametrised multi-channel TMDS encoder for the HDMI output path. It replaces the single-channel video/control encoder. Adds the following over that encoder:
- NUM_CH lanes sharing one mode select.
- TERC4 data-island encoding.
- Video and data-island guard bands.
- Clock enable.
- Configurable pipeline depth.

It sits between the video timing/packet mux and the 10:1 serialisers, one 10-bit word per lane per pixel clock.

Parameters:
NUM_CH, 3, number of TMDS lanes (1..4); lane 0 = blue/sync lane.
IN_REG, 1, 1 = register inputs before encoding (latency 2); 0 = no input register (latency 1).
ACC_W, 6, width of the signed running-disparity counter per lane.

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous active-high reset
i_ce  in  1  clock enable; pipeline and accumulators advance only when high
i_mode  in  3  0=control, 1=video, 2=video guard, 3=data island (TERC4), 4=data-island guard, 5-7 reserved
i_data  in  NUM_CH*8  video byte per lane, lane n at [8n+7:8n]
i_ctrl  in  NUM_CH*2  control bits per lane ({vsync,hsync} on lane 0; CTL pairs on others)
i_aux  in  NUM_CH*4  TERC4 nibble per lane
o_encoded  out  NUM_CH*10  TMDS word per lane, lane n at [10n+9:10n], bit 0 sent first

Behaviour:
Interface:
- Reset i_rst, synchronous, active-high; clock i_clk.

Reset state:
- All pipeline registers cleared.
- Every lane of o_encoded = 10'b1101010100 (control code 00).
- All disparity counters = 0.

Latency and clock enable:
- Latency = 1+IN_REG i_ce-qualified cycles from inputs to o_encoded.
- i_ce low: all registers and counters hold; o_encoded stable.

Video mode (per lane):
- n1 = ones in data byte.
- Transition minimisation:
  - Use XOR if n1<4, or if n1==4 and d[0]==1; q_m[8]=1.
  - Otherwise use XNOR; q_m[8]=0.
- Disparity d = ones(q_m[7:0]) - zeros(q_m[7:0]), always even, range -8..+8.
- If cnt==0 or d==0:
  - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - cnt += q_m[8] ? d : -d.
- Else if (cnt>0 and d>0) or (cnt<0 and d<0):
  - out = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2*q_m[8] - d.
- Else:
  - out = {0, q_m[8], q_m[7:0]}.
  - cnt += d - 2*(~q_m[8]).
- cnt is signed ACC_W two's complement; the sign test uses the MSB.
- Transition minimisation sits in the first stage (or is combinational if IN_REG=0); the DC-balance update sits in the output stage.

Non-video modes:
- Any non-video mode forces cnt=0 on the cycle it is encoded.
- A later return to video starts from cnt=0.

Control mode:
- ctrl 00 -> 1101010100
- ctrl 01 -> 0010101011
- ctrl 10 -> 0101010100
- ctrl 11 -> 1010101011

Data island (TERC4) lookup, nibble 0..F:
- 0 -> 1010011100, 1 -> 1001100011, 2 -> 1011100100, 3 -> 1011100010
- 4 -> 0101110001, 5 -> 0100011110, 6 -> 0110001110, 7 -> 0100111100
- 8 -> 1011001100, 9 -> 0100111001, A -> 0110011100, B -> 1011000110
- C -> 1010001110, D -> 1001110001, E -> 0101100011, F -> 1011000011

Video guard:
- Lanes 0 and 2 (and 3 if present) -> 1011001100.
- Lane 1 -> 0100110011.

Data-island guard:
- Lane 0 -> TERC4({2'b11, i_ctrl[1:0]}).
- Other lanes -> 0100110011.

Reserved modes 5-7:
- Encoded as control mode with each lane's i_ctrl.

Mode handling:
- A mode change takes effect on the very next enabled word; no bubble or glitch word.
- i_rst overrides i_ce. Reset mid-stream discards in-flight words; o_encoded shows the reset code the cycle after i_rst is sampled.

Optional Feature:
TMDS_DISP_MON_EN
- Defined:
  - Adds output o_disparity (NUM_CH*ACC_W): each lane's cnt, registered alongside o_encoded.
  - Adds output o_dc_err (1): sticky; set when any lane's |cnt| > 10 after an update; cleared only by i_rst.
- Undefined:
  - Neither port exists; no monitor logic is synthesised.

Test Plan:
1. Reset, then mode=1, lane0 data 0x00 for two enabled cycles -> lane0 outputs 10'h100 (cnt=-8), then 10'h3FF (cnt=+2).
2. mode=0, lane0 ctrl 01, lane1 ctrl 10, lane2 ctrl 11 -> 0010101011, 0101010100, 1010101011 after 2 cycles (IN_REG=1).
3. mode=3, aux 0x5/0x0/0xF on lanes 0/1/2 -> 0100011110 / 1010011100 / 1011000011. Then mode=4 with ctrl=2'b10 -> lane0 = TERC4(E) = 0101100011, lanes 1-2 = 0100110011.
4. Video 0x00 (cnt -8), one control word, video 0x00 -> second video word = 10'h100, not 10'h3FF (counter cleared).
5. Video stream with i_ce toggled 1,0,0,1 -> o_encoded holds over the ce-low cycles; sequence identical to the ce-always-high run.
6. i_rst asserted mid video stream for 1 cycle -> next o_encoded = 1101010100 on all lanes, cnt=0. With TMDS_DISP_MON_EN, o_disparity=0 and o_dc_err=0.
